// File: rtl/spi_shift_register.sv
// SPI shift register: serialises a byte onto mosi and assembles a byte from miso,
// driven by the edge strobes of an external baud rate generator.
module spi_shift_register (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       ss,
  input  logic       send_data,
  input  logic       lsbfe,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       flag_low,
  input  logic       flags_low,
  input  logic       flag_high,
  input  logic       flags_high,
  input  logic       miso,
  input  logic [7:0] data_mosi,
  output logic       mosi,
  output logic [7:0] data_miso,
  output logic       receive_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    XFER   = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_next_s;
  logic [7:0] tx_r;
  logic [7:0] rx_r;
  logic [7:0] rx_byte_s;
  logic [2:0] tx_cnt_r;
  logic [2:0] rx_cnt_r;
  logic [2:0] tx_idx_s;
  logic [2:0] rx_idx_s;
  logic       sel_s;
  logic       drive_evt_s;
  logic       sample_evt_s;
  logic       load_tx_s;
  logic       clr_cnt_s;
  logic       shift_out_s;
  logic       shift_in_s;
  logic       done_s;

  function automatic logic [2:0] bit_index(input logic [2:0] cnt, input logic lsb_first);
    logic [2:0] idx;
    if (lsb_first) begin
      idx = cnt;
    end else begin
      idx = 3'd7 - cnt;
    end
    return idx;
  endfunction

  // Event selection and bit addressing; rx_byte_s already contains the current miso bit
  always_comb begin
    sel_s = cpol ^ cpha;
    if (sel_s) begin
      drive_evt_s  = flags_high;
      sample_evt_s = flag_low;
    end else begin
      drive_evt_s  = flags_low;
      sample_evt_s = flag_high;
    end
    tx_idx_s            = bit_index(tx_cnt_r, lsbfe);
    rx_idx_s            = bit_index(rx_cnt_r, lsbfe);
    rx_byte_s           = rx_r;
    rx_byte_s[rx_idx_s] = miso;
  end

  // Next-state and datapath control
  always_comb begin
    state_next_s = state_r;
    load_tx_s    = 1'b0;
    clr_cnt_s    = 1'b0;
    shift_out_s  = 1'b0;
    shift_in_s   = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (send_data) begin
          state_next_s = LOADED;
          load_tx_s    = 1'b1;
          clr_cnt_s    = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOADED: begin
        if (send_data) begin
          state_next_s = LOADED;
          load_tx_s    = 1'b1;
          clr_cnt_s    = 1'b1;
        end else if (!ss) begin
          state_next_s = XFER;
        end else begin
          state_next_s = LOADED;
        end
      end
      XFER: begin
        if (ss) begin
          // abort: mosi and data_miso keep their values
          state_next_s = IDLE;
          clr_cnt_s    = 1'b1;
        end else begin
          shift_out_s = drive_evt_s;
          shift_in_s  = sample_evt_s;
          if (sample_evt_s && (rx_cnt_r == 3'd7)) begin
            state_next_s = IDLE;
            done_s       = 1'b1;
            clr_cnt_s    = 1'b1;
          end else begin
            state_next_s = XFER;
          end
        end
      end
      default: begin
        state_next_s = IDLE;
        clr_cnt_s    = 1'b1;
      end
    endcase
  end

  // State register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Transmit register and serial output
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tx_r <= 8'h00;
      mosi <= 1'b0;
    end else begin
      if (load_tx_s) begin
        tx_r <= data_mosi;
      end
      if (shift_out_s) begin
        mosi <= tx_r[tx_idx_s];
      end
    end
  end

  // Bit counters; completion and abort take priority over increments
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tx_cnt_r <= 3'd0;
      rx_cnt_r <= 3'd0;
    end else if (clr_cnt_s) begin
      tx_cnt_r <= 3'd0;
      rx_cnt_r <= 3'd0;
    end else begin
      if (shift_out_s) begin
        tx_cnt_r <= tx_cnt_r + 3'd1;
      end
      if (shift_in_s) begin
        rx_cnt_r <= rx_cnt_r + 3'd1;
      end
    end
  end

  // Receive register, completed byte and its strobe
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rx_r         <= 8'h00;
      data_miso    <= 8'h00;
      receive_data <= 1'b0;
    end else begin
      if (shift_in_s) begin
        rx_r <= rx_byte_s;
      end
      if (done_s) begin
        data_miso <= rx_byte_s;
      end
      receive_data <= done_s;
    end
  end

endmodule

// File: tb/tb_spi_shift_register.sv
// Bench for spi_shift_register: table of full transfers plus hand-built corner sequences,
// with queued expectations for mosi bits and received bytes.
module tb_spi_shift_register;

  logic       PCLK;
  logic       PRESET;
  logic       ss;
  logic       send_data;
  logic       lsbfe;
  logic       cpol;
  logic       cpha;
  logic       flag_low;
  logic       flags_low;
  logic       flag_high;
  logic       flags_high;
  logic       miso;
  logic [7:0] data_mosi;
  logic       mosi;
  logic [7:0] data_miso;
  logic       receive_data;

  int n_cmp;
  int n_err;

  logic       exp_mosi_q[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] last_rx_exp;
  logic       last_mosi_exp;

  // mosi_seq / miso_seq: bit 7 is the first bit on the wire
  typedef struct packed {
    logic       cpol;
    logic       cpha;
    logic       lsbfe;
    logic [7:0] tx;
    logic [7:0] mosi_seq;
    logic [7:0] miso_seq;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  spi_shift_register dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .ss          (ss),
    .send_data   (send_data),
    .lsbfe       (lsbfe),
    .cpol        (cpol),
    .cpha        (cpha),
    .flag_low    (flag_low),
    .flags_low   (flags_low),
    .flag_high   (flag_high),
    .flags_high  (flags_high),
    .miso        (miso),
    .data_mosi   (data_mosi),
    .mosi        (mosi),
    .data_miso   (data_miso),
    .receive_data(receive_data)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0b required %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %02h required %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic set_drive(input logic v);
    if (cpol ^ cpha) flags_high = v;
    else             flags_low  = v;
  endtask

  task automatic set_sample(input logic v);
    if (cpol ^ cpha) flag_low  = v;
    else             flag_high = v;
  endtask

  task automatic load(input logic [7:0] d);
    ss        = 1'b1;
    data_mosi = d;
    send_data = 1'b1;
    tick();
    send_data = 1'b0;
    ss        = 1'b0;
    tick();
  endtask

  task automatic check_rx_done();
    logic [7:0] e;
    check1("rd_pulse", receive_data, 1'b1);
    if (exp_rx_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL rx_queue: actual empty required an entry (t=%0t)", $time);
    end else begin
      e = exp_rx_q.pop_front();
      check8("data_miso", data_miso, e);
      last_rx_exp = e;
    end
    tick();
    check1("rd_one_cycle", receive_data, 1'b0);
    check8("data_miso_hold", data_miso, last_rx_exp);
  endtask

  task automatic xfer_bit(input logic exp_bit, input logic miso_bit, input logic last,
                          input logic together);
    logic e;
    exp_mosi_q.push_back(exp_bit);
    miso = miso_bit;
    set_drive(1'b1);
    if (together) set_sample(1'b1);
    tick();
    set_drive(1'b0);
    if (exp_mosi_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL mosi_queue: actual empty required an entry (t=%0t)", $time);
    end else begin
      e = exp_mosi_q.pop_front();
      check1("mosi_drive", mosi, e);
      last_mosi_exp = e;
    end
    if (!together) begin
      check1("rd_mid", receive_data, 1'b0);
      set_sample(1'b1);
      tick();
    end
    set_sample(1'b0);
    if (last) check_rx_done();
    else      check1("rd_idle", receive_data, 1'b0);
    check1("mosi_hold", mosi, last_mosi_exp);
  endtask

  task automatic run_vec(input vec_t v, input logic together);
    cpol  = v.cpol;
    cpha  = v.cpha;
    lsbfe = v.lsbfe;
    exp_rx_q.push_back(v.exp_rx);
    load(v.tx);
    for (int i = 0; i < 8; i++) begin
      xfer_bit(v.mosi_seq[7-i], v.miso_seq[7-i], (i == 7), together);
    end
    ss = 1'b1;
  endtask

  initial begin
    logic [7:0] seq;
    n_cmp = 0;
    n_err = 0;
    {ss, send_data, lsbfe, cpol, cpha} = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    {flag_low, flags_low, flag_high, flags_high, miso} = 5'b00000;
    data_mosi     = 8'h00;
    last_rx_exp   = 8'h00;
    last_mosi_exp = 1'b0;
    PRESET        = 1'b1;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'hA5, 8'hA5, 8'hC3, 8'hC3};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 8'h01, 8'h80, 8'hFF, 8'hFF};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 8'h3C, 8'h3C, 8'h5A, 8'h5A};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 8'h96, 8'h69, 8'hB4, 8'h2D};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h5A, 8'h5A, 8'h0F, 8'h0F};

    tick();
    tick();
    check1("reset_mosi", mosi, 1'b0);
    check8("reset_data_miso", data_miso, 8'h00);
    check1("reset_rd", receive_data, 1'b0);
    @(negedge PCLK);
    PRESET = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b0);
    // drive and sample on the same cycle
    run_vec(vecs[2], 1'b1);

    // sel=1 with the sel=0 strobes: nothing moves, then the right strobes complete it
    cpol = 1'b1; cpha = 1'b0; lsbfe = 1'b0;
    load(8'hFF);
    for (int i = 0; i < 8; i++) begin
      flags_low = 1'b1; flag_high = 1'b1; miso = 1'b1;
      tick();
      flags_low = 1'b0; flag_high = 1'b0;
      check1("wrong_evt_mosi", mosi, last_mosi_exp);
      check1("wrong_evt_rd", receive_data, 1'b0);
      check8("wrong_evt_data_miso", data_miso, last_rx_exp);
    end
    seq = 8'hE1;
    exp_rx_q.push_back(8'hE1);
    for (int i = 0; i < 8; i++) xfer_bit(1'b1, seq[7-i], (i == 7), 1'b0);
    ss = 1'b1;

    // abort after four samples leaves the previous byte alone
    run_vec('{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h3C, 8'h3C}, 1'b0);
    load(8'hF0);
    for (int i = 0; i < 4; i++) xfer_bit(1'b1, 1'b1, 1'b0, 1'b0);
    ss = 1'b1;
    tick();
    check1("abort_rd", receive_data, 1'b0);
    check8("abort_data_miso", data_miso, 8'h3C);
    check1("abort_mosi", mosi, 1'b1);
    tick();
    check1("abort_rd_later", receive_data, 1'b0);
    run_vec('{1'b0, 1'b0, 1'b0, 8'h81, 8'h81, 8'h7E, 8'h7E}, 1'b0);

    // send_data during the transfer is ignored
    seq = 8'h99;
    exp_rx_q.push_back(8'h99);
    load(8'h00);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        data_mosi = 8'hFF; send_data = 1'b1;
        tick();
        send_data = 1'b0;
        check1("ignored_load_mosi", mosi, 1'b0);
      end
      xfer_bit(1'b0, seq[7-i], (i == 7), 1'b0);
    end
    ss = 1'b1;

    // second send_data while LOADED replaces the byte
    seq = 8'h24;
    ss = 1'b1; data_mosi = 8'h11; send_data = 1'b1;
    tick();
    data_mosi = 8'hE7;
    tick();
    send_data = 1'b0; ss = 1'b0;
    tick();
    exp_rx_q.push_back(8'h24);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] txs;
      txs = 8'hE7;
      xfer_bit(txs[7-i], seq[7-i], (i == 7), 1'b0);
    end
    ss = 1'b1;

    // asynchronous reset mid-transfer
    load(8'hAA);
    for (int i = 0; i < 3; i++) xfer_bit(i[0] ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    PRESET = 1'b1;
    #1;
    check1("midreset_mosi", mosi, 1'b0);
    check8("midreset_data_miso", data_miso, 8'h00);
    check1("midreset_rd", receive_data, 1'b0);
    #1;
    PRESET = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) begin
      set_drive(1'b1); set_sample(1'b1); miso = 1'b1;
      tick();
      set_drive(1'b0); set_sample(1'b0);
      check1("post_reset_mosi", mosi, 1'b0);
      check1("post_reset_rd", receive_data, 1'b0);
      check8("post_reset_data_miso", data_miso, 8'h00);
    end
    ss = 1'b1;
    run_vec(vecs[0], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_shift_register.md
SPI_SHIFT_REGISTER -- requirements
Module: spi_shift_register

Interface
REQ-001 The block SHALL have the following ports (name, direction, width, meaning), clock and reset first:
  - PCLK, input, 1: system clock; all state changes on its rising edge.
  - PRESET, input, 1: asynchronous, active-high reset.
  - ss, input, 1: slave select, active low; 0 = transfer enabled.
  - send_data, input, 1: one-cycle strobe; load data_mosi into the TX register.
  - lsbfe, input, 1: 1 = LSB first, 0 = MSB first.
  - cpol, input, 1: clock polarity.
  - cpha, input, 1: clock phase.
  - flag_low, input, 1: pulse coincident with the sclk falling-edge cycle, from the baud rate generator.
  - flags_low, input, 1: pulse one cycle before the sclk falling edge.
  - flag_high, input, 1: pulse coincident with the sclk rising-edge cycle.
  - flags_high, input, 1: pulse one cycle before the sclk rising edge.
  - miso, input, 1: serial data in.
  - data_mosi, input, 8: parallel byte to transmit.
  - mosi, output, 1: serial data out.
  - data_miso, output, 8: last fully received byte.
  - receive_data, output, 1: one-cycle pulse when data_miso updates.
REQ-002 There SHALL be one clock (PCLK). Reset (PRESET) SHALL be asynchronous and active-high.

Function
REQ-003 sel = cpol XOR cpha.
  - sel=0: drive event = flags_low; sample event = flag_high.
  - sel=1: drive event = flags_high; sample event = flag_low.
REQ-004 The FSM SHALL have three states: IDLE, LOADED, XFER.
REQ-005 IDLE → LOADED on send_data=1. The TX register captures data_mosi on that cycle, and tx_cnt and rx_cnt clear to 0.
REQ-006 LOADED → XFER on the first cycle with ss=0.
  - send_data in LOADED reloads the TX register and stays in LOADED.
REQ-007 In XFER, each drive event SHALL register mosi from the TX register, then increment tx_cnt (3 bits).
  - Bit index = tx_cnt if lsbfe=1, else 7−tx_cnt.
REQ-008 In XFER, each sample event SHALL write miso into the RX register, then increment rx_cnt (3 bits).
  - Bit index = rx_cnt if lsbfe=1, else 7−rx_cnt.
REQ-009 On the sample event with rx_cnt=7:
  - data_miso SHALL update on the next PCLK edge with the completed byte, including the current miso bit.
  - receive_data SHALL be 1 for exactly that one cycle.
  - The FSM SHALL return to IDLE, and counters SHALL wrap to 0.
REQ-010 Latency: the sample event at the 8th bit to the data_miso/receive_data update is 1 PCLK cycle.
REQ-011 send_data during XFER SHALL be ignored, and the TX register SHALL not change.
REQ-012 ss=1 during XFER SHALL abort:
  - FSM → IDLE, counters → 0.
  - No receive_data pulse; data_miso keeps its previous value.
  - mosi holds its last value.
REQ-013 Drive and sample events in the same cycle SHALL both take effect independently.
REQ-014 Events outside XFER SHALL have no effect on counters, mosi or the RX register.
REQ-015 lsbfe, cpol and cpha SHALL be sampled combinationally each event. Changing them mid-transfer is permitted but gives undefined bit order.
REQ-016 mosi SHALL hold its value between drive events. It is not tri-stated.

Reset
REQ-017 While PRESET=1, independent of PCLK:
  - mosi=0, data_miso=8'h00, receive_data=0.
  - TX and RX registers = 8'h00, tx_cnt = rx_cnt = 0, FSM=IDLE.
REQ-018 PRESET asserted mid-XFER SHALL discard the transfer with no receive_data pulse. After release the block SHALL wait in IDLE for send_data.

Verification
REQ-019 Mode 0, MSB first:
  - Stimulus: cpol=0, cpha=0, lsbfe=0, data_mosi=8'hA5, send_data pulse, ss=0, miso pattern 1,1,0,0,0,0,1,1 on flag_high.
  - Response: mosi sequence 1,0,1,0,0,1,0,1 on flags_low; data_miso=8'hC3; a single receive_data pulse one cycle after the 8th flag_high.
REQ-020 LSB first:
  - Stimulus: lsbfe=1, data_mosi=8'h01, miso held 1.
  - Response: mosi sequence 1,0,0,0,0,0,0,0; data_miso=8'hFF.
REQ-021 sel=1 (cpol=1, cpha=0):
  - Stimulus: pulses on flags_low and flag_high only.
  - Response: mosi and data_miso unchanged and no receive_data.
  - Follow-on: switch the pulses to flags_high and flag_low → transfer completes normally.
REQ-022 Abort:
  - Stimulus: ss to 1 after 4 sample events with previous data_miso=8'h3C.
  - Response: no receive_data; data_miso stays 8'h3C.
  - Follow-on: a new send_data followed by a full transfer yields the correct byte.
REQ-023 Reset mid-transfer:
  - Stimulus: PRESET=1 between PCLK edges during XFER.
  - Response: immediate mosi=0, data_miso=8'h00, receive_data=0; FSM=IDLE after release.
REQ-024 Ignored load:
  - Stimulus: send_data with data_mosi=8'hFF at bit 3 of a 8'h00 transfer.
  - Response: all 8 mosi bits are 0.
